spi_responder: RTL and testbench
================================

# spi_responder

SPI responder (slave) for the team's SPI serial link. It answers the 17-bit frames produced by the SPI initiator: 1 transaction bit, ADDR_WIDTH address bits, then DATA_WIDTH data bits. It sits on the far side of the link, in front of a local register file of NUM_REGS entries. It oversamples SCLK, CS_n and MOSI with its own clock, writes register contents on write frames, and serialises register contents onto MISO on read frames.

## Interface
- DATA_WIDTH, 8, data field and register width
- ADDR_WIDTH, 8, address field width
- NUM_REGS, 16, implemented registers (addresses 0..NUM_REGS-1)
- CLK  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- SCLK  in  1  serial clock from initiator; asynchronous to CLK
- CS_n  in  1  chip select, active low; asynchronous
- MOSI  in  1  serial data from initiator
- MISO  out  1  serial data to initiator; 1'bz whenever synchronised CS_n is high
- reg_wr_en  out  1  one-CLK pulse when a register is written
- reg_wr_addr  out  ADDR_WIDTH  address of the last write
- reg_wr_data  out  DATA_WIDTH  data of the last write
- host_rd_addr  in  ADDR_WIDTH  local read address
- host_rd_data  out  DATA_WIDTH  combinational read of register file; 0 if out of range
- frame_err  out  1  one-CLK pulse on aborted or out-of-range frame
- busy  out  1  high while a frame is in progress (state != IDLE)

## Operation
- SCLK, CS_n and MOSI each pass through a 2-flop synchroniser. A third SCLK flop provides edge detection: rise = s2 & ~s3, fall = ~s2 & s3.
- SPI mode 0:
  - MOSI is sampled on the detected SCLK rise.
  - MISO changes only on the detected SCLK fall, or when entering a state.
- Frame layout, MSB first on MOSI:
  - bit 0: Wr (1 = write, 0 = read)
  - next ADDR_WIDTH bits: address
  - next DATA_WIDTH bits: data (write frames only; MOSI ignored during data phase of reads)
- States: IDLE, CMD, ADDR, DATA, DONE. A 4-bit bit counter is cleared on every state entry.
  - IDLE: moves to CMD when synchronised CS_n goes low.
  - CMD: on rise, latches Wr and moves to ADDR.
  - ADDR: shifts in ADDR_WIDTH bits. On the last rise:
    - latches the address;
    - loads the read shifter with reg[addr], or 0 if addr >= NUM_REGS;
    - moves to DATA.
  - DATA, read frame: MISO is driven LSB first. Bit 0 is presented on the first fall after entering DATA; each following fall presents the next bit.
  - DATA, write frame: shifts MOSI in on each rise. After DATA_WIDTH rises, goes to DONE.
  - DATA exit to DONE:
    - in-range write: updates reg[addr] and pulses reg_wr_en;
    - out-of-range write: no update, pulses frame_err;
    - read: no further action.
  - DONE: ignores further SCLK edges; MISO is held at the last bit. Moves to IDLE when CS_n goes high.
- CS_n high in CMD, ADDR or DATA aborts the frame:
  - no register update;
  - frame_err pulses;
  - return to IDLE.
- MISO is 1'bz in IDLE. In CMD and ADDR it is driven 0.
- Simultaneous register write and host_rd_addr to the same entry: host_rd_data shows the old value in that cycle and the new value from the next cycle.

## Timing
- Reset values:
  - MISO = 1'bz; reg_wr_en = 0; reg_wr_addr = 0; reg_wr_data = 0;
  - frame_err = 0; busy = 0; all registers 0; state IDLE.
- Edge recognition latency is 3 CLK from the pin edge to the rise/fall pulse.
- SCLK high and low times must each be at least 3 CLK, so SCLK <= CLK/6.
- Write commit: reg_wr_en, reg_wr_addr, reg_wr_data and the register update all occur on the CLK edge after the final data rise is detected.
- MISO is updated within 1 CLK of the fall detection.
- Back-to-back frames: CS_n must stay high for at least 3 CLK between frames.
- reset asserted mid-frame: the block returns to reset values immediately and the register contents are cleared.

## Configuration
- SPI_RESP_WR_ECHO_EN
  - Defined: during the DATA phase of a write frame, MISO shifts out the register's old value LSB first, the same way as a read, so the initiator sees the prior contents.
  - Undefined: MISO is driven 0 during the write DATA phase.

## Test plan
- Write frame Wr=1, addr 0x03, data 0xA5 -> reg_wr_en pulses once; reg_wr_addr=0x03; reg_wr_data=0xA5; host_rd_addr=0x03 returns 0xA5.
- Read frame Wr=0, addr 0x03 after the write above -> MISO bits on successive falls 1,0,1,0,0,1,0,1 (LSB first); the initiator assembles 0xA5.
- Write to addr 0x20 (>= NUM_REGS) -> no reg_wr_en; frame_err pulses once. A read of 0x20 returns 0x00 and also pulses frame_err.
- CS_n released after 5 data bits of a write to 0x01 -> reg[1] unchanged, frame_err pulses, busy drops, MISO = z.
- With SPI_RESP_WR_ECHO_EN defined, write 0x3C to 0x02 holding 0xFF -> MISO shows eight 1s and reg[2]=0x3C. Undefined -> MISO shows eight 0s.
- reset pulsed during the ADDR phase -> all outputs return to reset values and reg file reads 0; the next full frame completes normally.

Source files
------------

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder in front of a small local register file.
// Frames arrive MSB first as {wr, addr[ADDR_WIDTH], data[DATA_WIDTH]}. Write
// frames update the register file. Read frames return the register LSB first
// on MISO.
// Optional feature: define SPI_RESP_WR_ECHO_EN so that, during the data phase
// of a write frame, MISO shifts out the register's old value.
// Ports:
//   CLK, reset          system clock, asynchronous active-high reset
//   SCLK, CS_n, MOSI    SPI inputs, asynchronous to CLK (synchronised here)
//   MISO                SPI output, 1'bz while deselected or idle
//   reg_wr_en/addr/data one-cycle write pulse and the last committed write
//   host_rd_addr/data   combinational local read port (0 when out of range)
//   frame_err           one-cycle pulse on an aborted or out-of-range frame
//   busy                high while a frame is in progress
module spi_responder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  CS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  reg_wr_en,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
`ifdef SPI_RESP_WR_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    // Synchronisers; the third SCLK stage feeds edge detection.
    logic [2:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    logic sclk_rise, sclk_fall, cs_low, mosi_s;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rd_sh_q, rd_sh_d;
    logic                  miso_q, miso_d;
    logic                  reg_wr_en_q, reg_wr_en_d;
    logic [ADDR_WIDTH-1:0] reg_wr_addr_q, reg_wr_addr_d;
    logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_low    = ~cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a < NUM_REGS_A;
    endfunction

    // Next-state and datapath for the frame FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rd_sh_d       = rd_sh_q;
        miso_d        = miso_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        frame_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                if (cs_low) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                end
            end
            S_CMD: begin
                if (!cs_low) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    wr_d    = mosi_s;
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                if (!cs_low) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    addr_d = {addr_q[ADDR_WIDTH-2:0], mosi_s};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == ADDR_LAST) begin
                        // Prime the read shifter with the addressed register.
                        rd_sh_d = in_range(addr_d) ? regs_q[IDX_W'(addr_d)] : '0;
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (!cs_low) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    // Reads (and echoing writes) present the next bit on each fall.
                    if (sclk_fall) begin
                        if (!wr_q || ECHO) begin
                            miso_d  = rd_sh_q[0];
                            rd_sh_d = rd_sh_q >> 1;
                        end else begin
                            miso_d = 1'b0;
                        end
                    end
                    if (sclk_rise) begin
                        data_d = {data_q[DATA_WIDTH-2:0], mosi_s};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == DATA_LAST) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                            if (!in_range(addr_q)) begin
                                frame_err_d = 1'b1;
                            end else if (wr_q) begin
                                reg_wr_en_d   = 1'b1;
                                reg_wr_addr_d = addr_q;
                                reg_wr_data_d = data_d;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                if (!cs_low) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            rd_sh_q       <= '0;
            miso_q        <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            sclk_sync_q   <= {sclk_sync_q[1:0], SCLK};
            cs_sync_q     <= {cs_sync_q[0], CS_n};
            mosi_sync_q   <= {mosi_sync_q[0], MOSI};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rd_sh_q       <= rd_sh_d;
            miso_q        <= miso_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
            if (reg_wr_en_d) begin
                regs_q[IDX_W'(reg_wr_addr_d)] <= reg_wr_data_d;
            end
        end
    end

    // Released whenever the initiator deselects us or the FSM is idle.
    assign MISO = (cs_sync_q[1] || state_q == S_IDLE) ? 1'bz : miso_q;

    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

    assign host_rd_data = in_range(host_rd_addr) ? regs_q[IDX_W'(host_rd_addr)] : '0;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed bench for spi_responder. Plays SPI mode-0
// frames, captures MISO on each SCLK rise like an initiator would, and
// compares against hand-computed values.
module tb_spi_responder;

    localparam int unsigned H = 5;  // SCLK half period in CLK cycles

    logic       CLK = 1'b0;
    logic       reset;
    logic       SCLK;
    logic       CS_n;
    logic       MOSI;
    wire        MISO;
    logic       reg_wr_en;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] host_rd_addr;
    logic [7:0] host_rd_data;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_pulses = 0;
    int err_pulses = 0;

    spi_responder dut (
        .CLK          (CLK),
        .reset        (reset),
        .SCLK         (SCLK),
        .CS_n         (CS_n),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    // Running pulse totals; tests look at the difference across a frame.
    always @(negedge CLK) begin
        if (reg_wr_en === 1'b1) wr_pulses++;
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives the first nbits of {wr, addr, data}; CS_n is left low.
    task automatic send_bits(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                             input int nbits, output logic [7:0] rd);
        logic [16:0] frame;
        frame = {wr, addr, data};
        rd = '0;
        CS_n = 1'b0;
        repeat (4) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            MOSI = frame[16-i];
            repeat (H) @(negedge CLK);
            if (i >= 9) rd[i-9] = MISO;
            SCLK = 1'b1;
            repeat (H) @(negedge CLK);
            SCLK = 1'b0;
        end
        repeat (H) @(negedge CLK);
    endtask

    task automatic end_frame();
        CS_n = 1'b1;
        MOSI = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic peek(input logic [7:0] a, input string tag, input logic [7:0] exp);
        host_rd_addr = a;
        #1;
        check(tag, {24'b0, host_rd_data}, {24'b0, exp});
    endtask

    initial begin
        logic [7:0] rd;
        int w0, e0;
        logic [7:0] echo_exp;

        reset = 1'b1; SCLK = 1'b0; CS_n = 1'b1; MOSI = 1'b0; host_rd_addr = '0;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_miso_z", {31'b0, MISO === 1'bz}, 1);
        check("rst_wr_en", {31'b0, reg_wr_en}, 0);
        check("rst_wr_addr", {24'b0, reg_wr_addr}, 0);
        check("rst_wr_data", {24'b0, reg_wr_data}, 0);
        check("rst_ferr", {31'b0, frame_err}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        peek(8'h03, "rst_reg3", 8'h00);

        // Write 0xA5 to 0x03
        w0 = wr_pulses; e0 = err_pulses;
        send_bits(1'b1, 8'h03, 8'hA5, 17, rd);
        check("wr_busy", {31'b0, busy}, 1);
        end_frame();
        check("wr_pulses", wr_pulses - w0, 1);
        check("wr_errs", err_pulses - e0, 0);
        check("wr_addr", {24'b0, reg_wr_addr}, 32'h03);
        check("wr_data", {24'b0, reg_wr_data}, 32'hA5);
        peek(8'h03, "wr_host_rd", 8'hA5);
        check("wr_idle_busy", {31'b0, busy}, 0);
        check("wr_idle_z", {31'b0, MISO === 1'bz}, 1);

        // Read back 0x03 (MISO 1,0,1,0,0,1,0,1 LSB first)
        w0 = wr_pulses; e0 = err_pulses;
        send_bits(1'b0, 8'h03, 8'h00, 17, rd);
        check("rd_done_hold", {31'b0, MISO}, 1);
        end_frame();
        check("rd_byte", {24'b0, rd}, 32'hA5);
        check("rd_no_wr", wr_pulses - w0, 0);
        check("rd_errs", err_pulses - e0, 0);

        // Out-of-range write and read at 0x20
        w0 = wr_pulses; e0 = err_pulses;
        send_bits(1'b1, 8'h20, 8'h5C, 17, rd);
        end_frame();
        check("oor_wr_pulses", wr_pulses - w0, 0);
        check("oor_wr_errs", err_pulses - e0, 1);
        e0 = err_pulses;
        send_bits(1'b0, 8'h20, 8'h00, 17, rd);
        end_frame();
        check("oor_rd_byte", {24'b0, rd}, 0);
        check("oor_rd_errs", err_pulses - e0, 1);
        peek(8'h20, "oor_host_rd", 8'h00);
        peek(8'h0F, "last_reg_host_rd", 8'h00);

        // Abort a write to 0x01 after 5 data bits
        send_bits(1'b1, 8'h01, 8'h5A, 17, rd);
        end_frame();
        w0 = wr_pulses; e0 = err_pulses;
        send_bits(1'b1, 8'h01, 8'h77, 14, rd);
        end_frame();
        check("abort_wr_pulses", wr_pulses - w0, 0);
        check("abort_errs", err_pulses - e0, 1);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_z", {31'b0, MISO === 1'bz}, 1);
        peek(8'h01, "abort_reg1", 8'h5A);

        // Write-echo behaviour on 0x02 holding 0xFF
        send_bits(1'b1, 8'h02, 8'hFF, 17, rd);
        end_frame();
        send_bits(1'b1, 8'h02, 8'h3C, 17, rd);
        end_frame();
`ifdef SPI_RESP_WR_ECHO_EN
        echo_exp = 8'hFF;
`else
        echo_exp = 8'h00;
`endif
        check("echo_miso", {24'b0, rd}, {24'b0, echo_exp});
        peek(8'h02, "echo_reg2", 8'h3C);

        // Reset during the ADDR phase
        send_bits(1'b1, 8'h05, 8'h11, 5, rd);
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        check("mid_rst_miso_z", {31'b0, MISO === 1'bz}, 1);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_wr_en", {31'b0, reg_wr_en}, 0);
        check("mid_rst_wr_addr", {24'b0, reg_wr_addr}, 0);
        check("mid_rst_wr_data", {24'b0, reg_wr_data}, 0);
        check("mid_rst_ferr", {31'b0, frame_err}, 0);
        peek(8'h03, "mid_rst_reg3", 8'h00);
        peek(8'h02, "mid_rst_reg2", 8'h00);
        reset = 1'b0;
        SCLK = 1'b0;
        end_frame();

        w0 = wr_pulses; e0 = err_pulses;
        send_bits(1'b1, 8'h07, 8'hC3, 17, rd);
        end_frame();
        check("post_rst_pulses", wr_pulses - w0, 1);
        check("post_rst_errs", err_pulses - e0, 0);
        check("post_rst_addr", {24'b0, reg_wr_addr}, 32'h07);
        peek(8'h07, "post_rst_reg7", 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
